cmd_queue_writer: RTL

CMD_QUEUE_WRITER -- requirements
Module: cmd_queue_writer

---
 rtl/cmd_queue_writer_pkg.sv | 23 ++
 rtl/cmd_queue_writer_hold.sv | 50 +++++
 rtl/cmd_queue_writer.sv | 98 +++++++++
 3 files changed

// File: rtl/cmd_queue_writer_pkg.sv
// Shared types and constants for the command queue writer.
// Defines the command word layout and the session state encoding.
package cmd_queue_writer_pkg;

  localparam int unsigned CMD_OP_W       = 4;
  localparam int unsigned CMD_ARG_W      = 12;
  localparam int unsigned CMD_SIZE       = CMD_OP_W + CMD_ARG_W;
  // Command FIFO depth in entries; one entry per four command bits.
  localparam int unsigned CMD_FIFO_DEPTH = CMD_SIZE / 4;

  typedef struct packed {
    logic [CMD_OP_W-1:0]  op;
    logic [CMD_ARG_W-1:0] arg;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cmd_queue_writer_hold.sv
// Single-entry holding register between the host handshake and the FIFO write port.
// A load in the same cycle as an unload replaces the contents, so there is no bubble.
module cmd_queue_writer_hold
  import cmd_queue_writer_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_unload,
  input  cmd_t i_data,
  input  logic i_last,
  output logic o_valid,
  output cmd_t o_data,
  output logic o_last
);

  logic valid_q, valid_d;
  cmd_t data_q, data_d;
  logic last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (i_load) begin
      valid_d = 1'b1;
      data_d  = i_data;
      last_d  = i_last;
    end else if (i_unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

endmodule

// File: rtl/cmd_queue_writer.sv
// Loads a session of host commands into the processor-array command FIFO,
// then waits for the FIFO to drain and the array to finish before signalling done.
module cmd_queue_writer
  import cmd_queue_writer_pkg::*;
#(
  parameter int unsigned DEPTH = CMD_FIFO_DEPTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  cmd_t                       i_cmd,
  input  logic                       i_cmd_last,
  input  logic [$clog2(DEPTH):0]     i_fifo_count,
  input  logic                       i_fifo_empty,
  output logic                       o_fifo_write,
  output cmd_t                       o_fifo_data,
  input  logic                       i_finished_task,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [CNT_W-1:0]           o_pushed
);

  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pushed_q, pushed_d;

  logic hold_valid;
  cmd_t hold_data;
  logic hold_last;

  logic fifo_has_room;
  logic fifo_wr;
  logic cmd_ready;
  logic cmd_accept;

  // Write/accept decisions are combinational so the holding register streams at full rate.
  always_comb begin
    fifo_has_room = (i_fifo_count < FCNT_W'(DEPTH));
    fifo_wr       = hold_valid & fifo_has_room;
    cmd_ready     = (state_q == ST_LOAD) & (~hold_valid | (fifo_wr & ~hold_last));
    cmd_accept    = i_cmd_valid & cmd_ready;
  end

  cmd_queue_writer_hold u_hold (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (cmd_accept),
    .i_unload (fifo_wr),
    .i_data   (i_cmd),
    .i_last   (i_cmd_last),
    .o_valid  (hold_valid),
    .o_data   (hold_data),
    .o_last   (hold_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_LOAD;
      ST_LOAD:  if (fifo_wr && hold_last) state_d = ST_DRAIN;
      ST_DRAIN: if (i_fifo_empty && i_finished_task) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pushed counter saturates rather than wrapping; cleared only when a new session starts.
  always_comb begin
    pushed_d = pushed_q;
    if ((state_q == ST_IDLE) && i_start) begin
      pushed_d = '0;
    end else if (fifo_wr && (pushed_q != {CNT_W{1'b1}})) begin
      pushed_d = pushed_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      pushed_q <= '0;
    end else begin
      state_q  <= state_d;
      pushed_q <= pushed_d;
    end
  end

  assign o_cmd_ready  = cmd_ready;
  assign o_fifo_write = fifo_wr;
  assign o_fifo_data  = hold_data;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_pushed     = pushed_q;

endmodule
